aes128_key_expand_seq: RTL

//   Sequential AES-128 key schedule (FIPS-197 §5.2). Produces round keys 0..10, one per accepted beat.
//   Per round it forms SubWord(RotWord(w3)) and feeds that word to the existing RoundConst stage (Rcon XOR on byte 0).
//   It then chains the XORs into w[4i..4i+3].

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/RoundConst.sv | 12 +
 rtl/aes_sub_word.sv | 12 +
 rtl/aes128_key_expand_seq.sv | 103 ++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, key-schedule FSM encoding, and the byte/word
// helpers (S-box, RotWord, Rcon) used by the key schedule and the cipher datapath.
package aes_pkg;

   localparam int AES_NR = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } ks_state_t;

   // Forward S-box, entry 0 in the leftmost byte so SBOX_TBL[b] is Sbox(b).
   localparam logic [0:255][7:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[b];
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // Round constant for rounds 1..10; round 0 and out-of-range indices yield 00.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] c;
      case (r)
         4'd1:    c = 8'h01;
         4'd2:    c = 8'h02;
         4'd3:    c = 8'h04;
         4'd4:    c = 8'h08;
         4'd5:    c = 8'h10;
         4'd6:    c = 8'h20;
         4'd7:    c = 8'h40;
         4'd8:    c = 8'h80;
         4'd9:    c = 8'h1b;
         4'd10:   c = 8'h36;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/RoundConst.sv
// Round-constant stage: XORs Rcon[round] into byte 0 (MSB) of the substituted word.
module RoundConst
   import aes_pkg::*;
(
   input  logic [3:0]  i_round,
   input  logic [31:0] i_word,
   output logic [31:0] o_word
);

   assign o_word = {i_word[31:24] ^ rcon(i_round), i_word[23:0]};

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups across a 32-bit word.
module aes_sub_word
   import aes_pkg::*;
(
   input  logic [31:0] i_word,
   output logic [31:0] o_word
);

   assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                    sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/aes128_key_expand_seq.sv
// Sequential AES-128 key schedule: streams round keys 0..10 over a valid/ready
// handshake, computing each next key combinationally from the key being presented.
module aes128_key_expand_seq
   import aes_pkg::*;
#(
   parameter int NR       = AES_NR,
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [KEY_BITS-1:0] key_in,
   output logic                busy,
   output logic                rk_valid,
   input  logic                rk_ready,
   output logic [3:0]          rk_round,
   output logic [KEY_BITS-1:0] rk_data,
   output logic                done
);

   ks_state_t           r_state, w_state_nxt;
   logic [3:0]          r_round, w_round_nxt;
   logic [KEY_BITS-1:0] r_data,  w_data_nxt;
   logic                r_done,  w_done_nxt;

   logic [31:0] w_w0, w_w1, w_w2, w_w3;
   logic [31:0] w_rot, w_sub, w_t;
   logic [31:0] w_n0, w_n1, w_n2, w_n3;
   logic [3:0]  w_rcon_round;
   logic        w_accept;

   assign {w_w0, w_w1, w_w2, w_w3} = r_data;
   assign w_rot        = rot_word(w_w3);
   assign w_rcon_round = 4'(r_round + 4'd1);

   aes_sub_word u_sub_word (
      .i_word (w_rot),
      .o_word (w_sub)
   );

   RoundConst u_round_const (
      .i_round (w_rcon_round),
      .i_word  (w_sub),
      .o_word  (w_t)
   );

   // Chained XORs produce w[4i..4i+3] of the next round key.
   assign w_n0 = w_w0 ^ w_t;
   assign w_n1 = w_w1 ^ w_n0;
   assign w_n2 = w_w2 ^ w_n1;
   assign w_n3 = w_w3 ^ w_n2;

   assign w_accept = (r_state == ST_EMIT) && rk_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_round_nxt = r_round;
      w_data_nxt  = r_data;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_EMIT;
               w_round_nxt = 4'd0;
               w_data_nxt  = key_in;
            end
         end
         ST_EMIT: begin
            if (w_accept) begin
               if (r_round == 4'(NR)) begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_round_nxt = w_rcon_round;
                  w_data_nxt  = {w_n0, w_n1, w_n2, w_n3};
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_round <= 4'd0;
         r_data  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_round <= w_round_nxt;
         r_data  <= w_data_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign busy     = (r_state == ST_EMIT);
   assign rk_valid = (r_state == ST_EMIT);
   assign rk_round = r_round;
   assign rk_data  = r_data;
   assign done     = r_done;

endmodule
